// File: rtl/vga_pkg.sv
// Timing constants shared with the VGA sync generator, plus box geometry and palette.
package vga_pkg;

  localparam int unsigned POS_W       = 10;
  localparam int unsigned RGB_W       = 12;
  localparam int unsigned H_VIS_START = 144;
  localparam int unsigned V_VIS_START = 34;
  localparam int unsigned H_VIS       = 640;
  localparam int unsigned V_VIS       = 480;
  localparam int unsigned BOX_SIZE    = 32;
  localparam int unsigned STEP        = 2;
  localparam int unsigned INIT_X      = 0;
  localparam int unsigned INIT_Y      = 0;

  localparam logic [RGB_W-1:0] BG_COLOR     = 12'h000;
  localparam logic [RGB_W-1:0] BORDER_COLOR = 12'hFFF;

  typedef logic [POS_W-1:0] pos_t;
  typedef logic [RGB_W-1:0] rgb_t;

  // Box colour selected by the bounce counter.
  function automatic rgb_t palette(input logic [1:0] idx);
    case (idx)
      2'd0:    palette = 12'hF00;
      2'd1:    palette = 12'h0F0;
      2'd2:    palette = 12'h00F;
      default: palette = 12'hFF0;
    endcase
  endfunction

endpackage

// File: rtl/vga_box_motion.sv
// One axis of box motion: position and direction, with a bounce at 0 and at MAX.
module vga_box_motion
  import vga_pkg::*;
#(
  parameter int unsigned MAX  = 608,
  parameter int unsigned STEP = 2,
  parameter int unsigned INIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic update,
  output pos_t pos,
  output logic bounce_c
);

  logic             dir_neg;
  logic             next_dir_c;
  pos_t             next_pos_c;
  logic [POS_W:0]   pos_ext;
  logic [POS_W:0]   sum_c;

  assign pos_ext = {1'b0, pos};
  assign sum_c   = pos_ext + (POS_W+1)'(STEP);

  // Next position evaluated in one extra bit so the upper limit can never wrap.
  always_comb begin
    next_pos_c = pos;
    next_dir_c = dir_neg;
    bounce_c   = 1'b0;
    if (!dir_neg) begin
      if (sum_c >= (POS_W+1)'(MAX)) begin
        next_pos_c = POS_W'(MAX);
        next_dir_c = 1'b1;
        bounce_c   = 1'b1;
      end else begin
        next_pos_c = sum_c[POS_W-1:0];
      end
    end else begin
      if (pos_ext <= (POS_W+1)'(STEP)) begin
        next_pos_c = '0;
        next_dir_c = 1'b0;
        bounce_c   = 1'b1;
      end else begin
        next_pos_c = pos - POS_W'(STEP);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos     <= POS_W'(INIT);
      dir_neg <= 1'b0;
    end else if (update) begin
      pos     <= next_pos_c;
      dir_neg <= next_dir_c;
    end
  end

endmodule

// File: rtl/vga_box_renderer.sv
// Renders a bouncing box into the VGA pixel stream; all outputs one cycle after their inputs.
// Define VGA_BORDER_EN to draw a white one-pixel frame around the visible area.
module vga_box_renderer
  import vga_pkg::*;
(
  input  logic             vga_CLK,
  input  logic             vga_RST,
  input  logic [POS_W-1:0] position_x,
  input  logic [POS_W-1:0] position_y,
  input  logic             vga_Ready,
  input  logic             HSync,
  input  logic             VSync,
  input  logic             pause,
  output logic [RGB_W-1:0] rgb_out,
  output logic             HSync_out,
  output logic             VSync_out,
  output logic             frame_tick,
  output logic [1:0]       bounce_cnt
);

  localparam int unsigned MAX_X = H_VIS - BOX_SIZE;
  localparam int unsigned MAX_Y = V_VIS - BOX_SIZE;

  localparam logic [0:0] ST_WAIT   = 1'b0;
  localparam logic [0:0] ST_UPDATE = 1'b1;

  logic [0:0] state;
  logic [0:0] next_state;
  logic       update_c;
  logic       move_c;
  logic       bounce_x_c;
  logic       bounce_y_c;
  pos_t       box_x;
  pos_t       box_y;
  pos_t       vx;
  pos_t       vy;
  logic       in_box_c;
  rgb_t       pixel_c;

  always_ff @(posedge vga_CLK or posedge vga_RST) begin
    if (vga_RST) state <= ST_WAIT;
    else         state <= next_state;
  end

  // The (0,0) position lies in blanking, so moving the box there never tears a frame.
  always_comb begin
    next_state = state;
    case (state)
      ST_WAIT:   if (position_x == '0 && position_y == '0) next_state = ST_UPDATE;
      ST_UPDATE: next_state = ST_WAIT;
      default:   next_state = ST_WAIT;
    endcase
  end

  assign update_c = (state == ST_UPDATE);
  assign move_c   = update_c && !pause;

  vga_box_motion #(.MAX(MAX_X), .STEP(STEP), .INIT(INIT_X)) u_x (
    .clk      (vga_CLK),
    .rst      (vga_RST),
    .update   (move_c),
    .pos      (box_x),
    .bounce_c (bounce_x_c)
  );

  vga_box_motion #(.MAX(MAX_Y), .STEP(STEP), .INIT(INIT_Y)) u_y (
    .clk      (vga_CLK),
    .rst      (vga_RST),
    .update   (move_c),
    .pos      (box_y),
    .bounce_c (bounce_y_c)
  );

  assign vx = position_x - POS_W'(H_VIS_START);
  assign vy = position_y - POS_W'(V_VIS_START);

  assign in_box_c = ({1'b0, vx} >= {1'b0, box_x}) &&
                    ({1'b0, vx} <  {1'b0, box_x} + (POS_W+1)'(BOX_SIZE)) &&
                    ({1'b0, vy} >= {1'b0, box_y}) &&
                    ({1'b0, vy} <  {1'b0, box_y} + (POS_W+1)'(BOX_SIZE));

  // Colour priority: blanking, then box, then optional border, then background.
  always_comb begin
    pixel_c = '0;
    if (vga_Ready) begin
      if (in_box_c) begin
        pixel_c = palette(bounce_cnt);
      end else begin
`ifdef VGA_BORDER_EN
        if (vx == '0 || vx == POS_W'(H_VIS - 1) || vy == '0 || vy == POS_W'(V_VIS - 1))
          pixel_c = BORDER_COLOR;
        else
          pixel_c = BG_COLOR;
`else
        pixel_c = BG_COLOR;
`endif
      end
    end
  end

  always_ff @(posedge vga_CLK or posedge vga_RST) begin
    if (vga_RST) begin
      rgb_out    <= '0;
      HSync_out  <= 1'b0;
      VSync_out  <= 1'b0;
      frame_tick <= 1'b0;
      bounce_cnt <= 2'd0;
    end else begin
      rgb_out    <= pixel_c;
      HSync_out  <= HSync;
      VSync_out  <= VSync;
      frame_tick <= update_c;
      // A corner hit bounces both axes but still advances the palette by one.
      if (move_c && (bounce_x_c || bounce_y_c)) bounce_cnt <= bounce_cnt + 2'd1;
    end
  end

endmodule

// File: tb/tb_vga_box_renderer.sv
// Randomized bench for vga_box_renderer against a closed-form model of the box trajectory.
module tb_vga_box_renderer;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  px;
  logic [9:0]  py;
  logic        ready;
  logic        hs;
  logic        vs;
  logic        pause;
  logic [11:0] rgb;
  logic        hso;
  logic        vso;
  logic        tick;
  logic [1:0]  bcnt;

  int vectors     = 0;
  int miscompares = 0;
  int m_n         = 0;
  int pal [4]     = '{'hF00, 'h0F0, 'h00F, 'hFF0};

  always #5 clk = ~clk;

  vga_box_renderer dut (
    .vga_CLK    (clk),
    .vga_RST    (rst),
    .position_x (px),
    .position_y (py),
    .vga_Ready  (ready),
    .HSync      (hs),
    .VSync      (vs),
    .pause      (pause),
    .rgb_out    (rgb),
    .HSync_out  (hso),
    .VSync_out  (vso),
    .frame_tick (tick),
    .bounce_cnt (bcnt)
  );

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Box position after n moving frames is a triangle wave of period 2*MAX.
  function automatic int tri_pos(input int n, input int maxv);
    int p;
    p = (2 * n) % (2 * maxv);
    return (p <= maxv) ? p : 2 * maxv - p;
  endfunction

  function automatic int m_x();
    return tri_pos(m_n, 608);
  endfunction

  function automatic int m_y();
    return tri_pos(m_n, 448);
  endfunction

  // Bounce frames are multiples of 304 (X) or 224 (Y); corner hits counted once.
  function automatic int m_cnt();
    return ((2 * m_n) / 608 + (2 * m_n) / 448 - (2 * m_n) / 8512) % 4;
  endfunction

  function automatic int ref_pixel(input int x, input int y, input bit r);
    int vx;
    int vy;
    if (!r) return 0;
    vx = (x - 144) & 1023;
    vy = (y - 34) & 1023;
    if (vx >= m_x() && vx < m_x() + 32 && vy >= m_y() && vy < m_y() + 32)
      return pal[m_cnt()];
`ifdef VGA_BORDER_EN
    if (vx == 0 || vx == 639 || vy == 0 || vy == 479) return 'hFFF;
`endif
    return 'h000;
  endfunction

  task automatic drive(input int x, input int y, input bit r, input bit p);
    px    = 10'(x);
    py    = 10'(y);
    ready = r;
    hs    = 1'($urandom);
    vs    = 1'($urandom);
    pause = p;
  endtask

  // Single pixel; the caller never passes (0,0).
  task automatic pix(input string tag, input int x, input int y, input bit r);
    int  exp_rgb;
    logic exp_hs;
    logic exp_vs;
    drive(x, y, r, 1'b0);
    exp_rgb = ref_pixel(x, y, r);
    exp_hs  = hs;
    exp_vs  = vs;
    @(posedge clk);
    #1;
    check({tag, "_rgb"}, rgb, exp_rgb);
    check({tag, "_hsync"}, hso, exp_hs);
    check({tag, "_vsync"}, vso, exp_vs);
  endtask

  // Frame boundary: one (0,0) cycle, then the update cycle, then idle.
  task automatic frame(input bit p);
    drive(0, 0, 1'b0, p);
    @(posedge clk);
    #1;
    check("tick_before", tick, 0);
    drive(1, 0, 1'b0, p);
    @(posedge clk);
    #1;
    if (!p) m_n++;
    check("tick_pulse", tick, 1);
    check("bounce_cnt", bcnt, m_cnt());
    check("box_x", dut.box_x, m_x());
    check("box_y", dut.box_y, m_y());
    drive(2, 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("tick_after", tick, 0);
  endtask

  task automatic random_pixels();
    int x;
    int y;
    for (int k = 0; k < 3; k++) begin
      x = 144 + m_x() + int'($urandom_range(0, 35)) - 2;
      y = 34 + m_y() + int'($urandom_range(0, 35)) - 2;
      pix("near_box", x, y, 1'b1);
    end
    pix("edge_left", 144, int'($urandom_range(34, 513)), 1'b1);
    pix("edge_right", 783, int'($urandom_range(34, 513)), 1'b1);
    pix("random", int'($urandom_range(1, 799)), int'($urandom_range(0, 524)), 1'($urandom));
  endtask

  initial begin
    int prev_cnt;
    int cx;
    int cy;
    rst = 1'b1;
    drive(5, 5, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_rgb", rgb, 0);
    check("rst_hsync", hso, 0);
    check("rst_vsync", vso, 0);
    check("rst_tick", tick, 0);
    check("rst_bcnt", bcnt, 0);
    check("rst_box_x", dut.box_x, 0);
    @(negedge clk);
    rst = 1'b0;
    m_n = 0;

    pix("pre_frame", 146, 36, 1'b1);
    frame(1'b0);
    pix("first_in", 146, 36, 1'b1);
    check("first_in_const", rgb, 'hF00);
    pix("first_out", 145, 36, 1'b1);
    pix("border_px", 144, 100, 1'b1);

    for (int k = 0; k < 10; k++)
      pix("blank", 10, int'($urandom_range(0, 524)), 1'b0);

    for (int f = 2; f <= 4300; f++) begin
      prev_cnt = m_cnt();
      frame(1'b0);
      if (f == 304) check("x_at_304", dut.box_x, 608);
      if (f == 305) check("x_at_305", dut.box_x, 606);
      if (f == 4256) check("corner_bounce_once", bcnt, (prev_cnt + 1) % 4);
      if (f % 8 == 0) random_pixels();
    end

    for (int k = 0; k < 10; k++) frame(1'b1);
    frame(1'b0);
    random_pixels();

    // Reset asserted in the middle of a visible line over the box.
    cx = 144 + m_x() + 16;
    cy = 34 + m_y() + 16;
    pix("pre_reset_box", cx, cy, 1'b1);
    drive(400, 200, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    m_n = 0;
    check("midrst_rgb", rgb, 0);
    check("midrst_tick", tick, 0);
    check("midrst_bcnt", bcnt, 0);
    check("midrst_box_x", dut.box_x, 0);
    check("midrst_box_y", dut.box_y, 0);
    @(negedge clk);
    rst = 1'b0;
    pix("post_rst_pre", 400, 200, 1'b1);
    frame(1'b0);
    pix("post_rst_in", 146, 36, 1'b1);
    pix("post_rst_out", 145, 36, 1'b1);
    pix("post_rst_border", 144, 100, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_box_renderer.md
Name: vga_box_renderer

Overview:
Pixel-colour stage directly downstream of the VGA sync generator. Consumes its position_x/position_y/vga_Ready/HSync/VSync and renders a square box that moves and bounces off the edges of the 640x480 visible area. The box colour cycles through a 4-entry palette on each bounce. Outputs are registered 12-bit RGB plus sync signals delayed to stay aligned, feeding the DAC/pin stage.

Parameters:
H_VIS_START, 144, position_x of first visible pixel
V_VIS_START, 34, position_y of first visible line
H_VIS, 640, visible width
V_VIS, 480, visible height
BOX_SIZE, 32, box edge length in pixels
STEP, 2, pixels moved per frame per axis
INIT_X, 0, box left edge after reset (visible coords)
INIT_Y, 0, box top edge after reset
BG_COLOR, 12'h000, background RGB

Ports:
vga_CLK  in  1  pixel clock
vga_RST  in  1  asynchronous active-high reset
position_x  in  10  horizontal counter from the sync generator
position_y  in  10  vertical counter from the sync generator
vga_Ready  in  1  high in the visible region
HSync  in  1  horizontal sync from the sync generator
VSync  in  1  vertical sync from the sync generator
pause  in  1  freezes box motion while high
rgb_out  out  12  {R[3:0],G[3:0],B[3:0]}, registered
HSync_out  out  1  HSync delayed 1 cycle
VSync_out  out  1  VSync delayed 1 cycle
frame_tick  out  1  1-cycle pulse on each frame update
bounce_cnt  out  2  palette index; increments on each bounce frame

Behaviour:
- Reset (async): rgb_out=0, HSync_out=0, VSync_out=0, frame_tick=0, bounce_cnt=0, box_x=INIT_X, box_y=INIT_Y, dir_x=+, dir_y=+.
- Latency: 1 cycle for everything. rgb_out, HSync_out and VSync_out at cycle n+1 reflect the inputs at cycle n.
- Visible coords: vx=position_x-H_VIS_START, vy=position_y-V_VIS_START, 10-bit; these are only meaningful while vga_Ready=1.
- Pixel: if !vga_Ready -> rgb_out=0. Else if box_x<=vx<box_x+BOX_SIZE and box_y<=vy<box_y+BOX_SIZE -> PALETTE[bounce_cnt]. Else BG_COLOR.
- PALETTE is fixed: 0:12'hF00, 1:12'h0F0, 2:12'h00F, 3:12'hFF0.
- Update FSM: WAIT -> UPDATE when position_x==0 && position_y==0. UPDATE lasts 1 cycle and returns to WAIT.
  - This cycle is in blanking, so the new position never tears within a frame.
  - frame_tick=1 during the cycle after UPDATE is registered (one pulse per frame).
- Motion in UPDATE, per axis (X shown; Y uses V_VIS):
  - MAX = H_VIS-BOX_SIZE.
  - dir=+ and box_x+STEP>=MAX: box_x=MAX, dir=-, bounce.
  - dir=- and box_x<=STEP: box_x=0, dir=+, bounce.
  - Otherwise box_x+=STEP or -=STEP.
  - Compute in 11 bits; no wrap-around is allowed.
- Bounce on X, Y, or both in the same UPDATE: bounce_cnt increments by exactly 1, mod 4.
- pause=1 during UPDATE: position, dir and bounce_cnt are held. frame_tick still pulses.
- Reset mid-frame: state returns to reset values immediately. First motion occurs at the next (0,0).

Optional Feature:
VGA_BORDER_EN.
- Defined: visible pixels with vx==0, vx==H_VIS-1, vy==0 or vy==V_VIS-1 render 12'hFFF. Priority is box > border > background.
- Undefined: no border logic; those pixels follow the box/background rule.

Decomposition:
- Package vga_pkg holds the timing constants shared with the sync generator (visible start/size) and the palette constants.
- One sub-module: vga_box_motion. It holds the per-axis position/direction/bounce logic, is parameterised by MAX and STEP, and is instantiated twice (X, Y). It returns a bounce flag that the top ORs to drive bounce_cnt.

Test Plan:
- Reset, then first frame (defaults) -> at (0,0) the box moves to (2,2), frame_tick pulses once, bounce_cnt=0. Pixel (146,36) -> rgb_out=12'hF00 one cycle later. Pixel (145,36) -> 12'h000.
- Run 304 frames from reset -> box_x=608, dir_x=-, bounce_cnt=1. The 305th frame gives box_x=606.
- Sweep blanking (position_x=10, vga_Ready=0) -> rgb_out=0 regardless of box. HSync_out/VSync_out equal the inputs delayed exactly 1 cycle.
- INIT_X=INIT_Y=0 with dir forced by the corner case (INIT_X=INIT_Y=606 in a 640x640 variant) -> simultaneous X/Y bounce increments bounce_cnt by 1 only.
- pause=1 across 10 frames -> box and bounce_cnt unchanged, 10 frame_tick pulses. Release -> motion resumes at STEP.
- Assert vga_RST at position (400,200) -> outputs 0 immediately. Next frame starts from (INIT_X+2, INIT_Y+2). With VGA_BORDER_EN defined, pixel (144,100) -> 12'hFFF.
